// File: rtl/hasti_interconnect.sv
// Single-master, N-slave AHB-Lite interconnect: address decoder, data-phase response mux,
// built-in default slave, data-phase timeout and sticky first-error capture.
module hasti_interconnect #(
  parameter int          NSLAVES            = 3,
  parameter logic [31:0] SLV_BASE [NSLAVES] = '{32'h0000_0000, 32'h2000_0000, 32'h8000_0000},
  parameter logic [31:0] SLV_MASK [NSLAVES] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'h8000_0000},
  parameter int          TIMEOUT            = 256,
  parameter int          TCW                = 16
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [31:0]               m_haddr,
  input  logic                      m_hwrite,
  input  logic [2:0]                m_hsize,
  input  logic [2:0]                m_hburst,
  input  logic [3:0]                m_hprot,
  input  logic [1:0]                m_htrans,
  input  logic                      m_hmastlock,
  input  logic [31:0]               m_hwdata,
  output logic [31:0]               m_hrdata,
  output logic                      m_hresp,
  output logic                      m_hready,
  output logic [NSLAVES-1:0]        s_hsel,
  output logic [31:0]               s_haddr,
  output logic                      s_hwrite,
  output logic [2:0]                s_hsize,
  output logic [2:0]                s_hburst,
  output logic [3:0]                s_hprot,
  output logic [1:0]                s_htrans,
  output logic                      s_hmastlock,
  output logic [31:0]               s_hwdata,
  output logic                      s_hready,
  input  logic [NSLAVES-1:0][31:0]  s_hrdata,
  input  logic [NSLAVES-1:0]        s_hresp,
  input  logic [NSLAVES-1:0]        s_hreadyout,
  output logic                      err_valid,
  output logic                      err_cause,
  output logic [31:0]               err_addr,
  input  logic                      err_clr
);

  localparam int             IW            = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam logic [TCW-1:0] CNT_SAT       = (TIMEOUT == 0) ? {TCW{1'b1}} : TCW'(TIMEOUT);
  localparam logic [1:0]     HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]     HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {DP_IDLE, DP_SLV, DP_ERR1, DP_ERR2} dp_state_t;

  dp_state_t      r_state;
  logic [IW-1:0]  r_sel;
  logic [31:0]    r_haddr;
  logic [TCW-1:0] r_cnt;
  logic           r_err_valid;
  logic           r_err_cause;
  logic [31:0]    r_err_addr;

  logic           w_hit;
  logic [IW-1:0]  w_idx;
  logic           w_act;
  logic [TCW-1:0] w_cnt_inc;
  logic           w_timeout;
  logic           w_err_entry;
  logic [31:0]    w_err_addr;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((m_haddr & SLV_MASK[i]) == SLV_BASE[i]) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
    end
  end

  always_comb begin
    s_hsel = '0;
    if (w_hit) s_hsel[w_idx] = 1'b1;
  end

  assign w_act = (m_htrans == HTRANS_NONSEQ) || (m_htrans == HTRANS_SEQ);

  assign s_haddr     = m_haddr;
  assign s_hwrite    = m_hwrite;
  assign s_hsize     = m_hsize;
  assign s_hburst    = m_hburst;
  assign s_hprot     = m_hprot;
  assign s_htrans    = m_htrans;
  assign s_hmastlock = m_hmastlock;
  assign s_hwdata    = m_hwdata;
  assign s_hready    = m_hready;

  always_comb begin
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = '0;
    case (r_state)
      DP_SLV: begin
        m_hready = s_hreadyout[r_sel];
        m_hresp  = s_hresp[r_sel];
        m_hrdata = s_hrdata[r_sel];
      end
      DP_ERR1: begin
        m_hready = 1'b0;
        m_hresp  = 1'b1;
      end
      DP_ERR2: m_hresp = 1'b1;
      default: ;
    endcase
  end

  // Wait counter saturates; the timeout fires on the wait cycle that brings it to TIMEOUT.
  assign w_cnt_inc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout   = (TIMEOUT != 0) && (r_state == DP_SLV) && !s_hreadyout[r_sel] &&
                       (w_cnt_inc == CNT_SAT);
  assign w_err_entry = w_timeout || (m_hready && w_act && !w_hit);
  assign w_err_addr  = w_timeout ? r_haddr : m_haddr;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= DP_IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_err_valid <= 1'b0;
      r_err_cause <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      if (m_hready) begin
        r_sel <= w_idx;
        r_cnt <= '0;
        if (!w_act)      r_state <= DP_IDLE;
        else if (!w_hit) r_state <= DP_ERR1;
        else             r_state <= DP_SLV;
      end else begin
        case (r_state)
          DP_SLV: begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) r_state <= DP_ERR1;
          end
          DP_ERR1: r_state <= DP_ERR2;
          default: ;
        endcase
      end
      // A clear coinciding with a new error still records that error.
      if (w_err_entry && (!r_err_valid || err_clr)) begin
        r_err_valid <= 1'b1;
        r_err_cause <= w_timeout;
        r_err_addr  <= w_err_addr;
      end else if (err_clr) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (m_hready) r_haddr <= m_haddr;
  end

  assign err_valid = r_err_valid;
  assign err_cause = r_err_cause;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_hasti_interconnect.sv
// Directed bench for hasti_interconnect with a transfer-level reference model
// checked every cycle, plus hand-computed spot checks.
module tb_hasti_interconnect;

  localparam int          NS = 3;
  localparam int          TO = 4;
  localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h2000_0000, 32'h8000_0000};
  localparam logic [31:0] MASK [NS] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'h8000_0000};
  localparam logic [31:0] RD   [NS] = '{32'hAAAA_0000, 32'hBBBB_1111, 32'hCCCC_2222};
  localparam logic [1:0]  IDLE   = 2'b00;
  localparam logic [1:0]  NONSEQ = 2'b10;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic                hreset;
  logic [31:0]         m_haddr, m_hwdata, m_hrdata;
  logic                m_hwrite, m_hmastlock, m_hresp, m_hready;
  logic [2:0]          m_hsize, m_hburst;
  logic [3:0]          m_hprot;
  logic [1:0]          m_htrans;
  logic [NS-1:0]       s_hsel;
  logic [31:0]         s_haddr, s_hwdata;
  logic                s_hwrite, s_hmastlock, s_hready;
  logic [2:0]          s_hsize, s_hburst;
  logic [3:0]          s_hprot;
  logic [1:0]          s_htrans;
  logic [NS-1:0][31:0] s_hrdata;
  logic [NS-1:0]       s_hresp, s_hreadyout;
  logic                err_valid, err_cause, err_clr;
  logic [31:0]         err_addr;

  hasti_interconnect #(.NSLAVES(NS), .TIMEOUT(TO), .TCW(16)) dut (
    .hclk(hclk), .hreset(hreset),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
    .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
    .m_hrdata(m_hrdata), .m_hresp(m_hresp), .m_hready(m_hready),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hmastlock(s_hmastlock),
    .s_hwdata(s_hwdata), .s_hready(s_hready),
    .s_hrdata(s_hrdata), .s_hresp(s_hresp), .s_hreadyout(s_hreadyout),
    .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr), .err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the transfer currently in its data phase and its age in cycles.
  bit          md_live = 1'b0;
  bit          md_act;
  int          md_slv;
  logic [31:0] md_addr;
  int          md_age;
  bit          me_valid, me_cause;
  logic [31:0] me_addr;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  // Unmapped or timed-out transfers answer with two ERROR cycles, the second ready.
  function automatic void model_out(output logic rdy, output logic rsp, output logic [31:0] rd);
    int k;
    rdy = 1'b1; rsp = 1'b0; rd = '0;
    if (md_act) begin
      if (md_slv < 0 || md_age >= TO) begin
        k   = (md_slv < 0) ? md_age : md_age - TO;
        rdy = (k != 0);
        rsp = 1'b1;
      end else begin
        rdy = s_hreadyout[md_slv];
        rsp = s_hresp[md_slv];
        rd  = s_hrdata[md_slv];
      end
    end
  endfunction

  task automatic model_step();
    logic        rdy, rsp, ev, ec;
    logic [31:0] rd, ea;
    model_out(rdy, rsp, rd);
    ev = 1'b0; ec = 1'b0; ea = '0;
    if (hreset) begin
      md_live = 1'b1; md_act = 1'b0; md_slv = -1; md_age = 0;
      me_valid = 1'b0; me_cause = 1'b0; me_addr = '0;
    end else if (md_live) begin
      if (rdy) begin
        md_act  = m_htrans[1];
        md_slv  = decode(m_haddr);
        md_addr = m_haddr;
        md_age  = 0;
        if (md_act && md_slv < 0) begin ev = 1'b1; ec = 1'b0; ea = m_haddr; end
      end else begin
        md_age++;
        if (md_slv >= 0 && md_age == TO) begin ev = 1'b1; ec = 1'b1; ea = md_addr; end
      end
      if (ev && (!me_valid || err_clr)) begin
        me_valid = 1'b1; me_cause = ec; me_addr = ea;
      end else if (err_clr) begin
        me_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_cycle();
    logic          rdy, rsp;
    logic [31:0]   rd;
    logic [NS-1:0] esel;
    int            d;
    model_out(rdy, rsp, rd);
    d    = decode(m_haddr);
    esel = '0;
    if (d >= 0) esel[d] = 1'b1;
    chk("m_hready", m_hready, rdy);
    chk("m_hresp", m_hresp, rsp);
    chk("m_hrdata", m_hrdata, rd);
    chk("s_hready", s_hready, rdy);
    chk("s_hsel", s_hsel, esel);
    chk("s_haddr", s_haddr, m_haddr);
    chk("s_hwdata", s_hwdata, m_hwdata);
    chk("s_ctrl", {s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans, s_hmastlock},
        {m_hwrite, m_hsize, m_hburst, m_hprot, m_htrans, m_hmastlock});
    chk("err_valid", err_valid, me_valid);
    chk("err_cause", err_cause, me_cause);
    chk("err_addr", err_addr, me_addr);
  endtask

  initial forever @(posedge hclk) model_step();
  initial forever @(negedge hclk) if (md_live) compare_cycle();

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] tr, input logic wr);
    m_haddr  = a;
    m_htrans = tr;
    m_hwrite = wr;
    m_hwdata = ~a;
  endtask

  initial begin
    hreset = 1'b1; err_clr = 1'b0;
    m_hsize = 3'b010; m_hburst = 3'b000; m_hprot = 4'b0011; m_hmastlock = 1'b0;
    drive(32'h0, IDLE, 1'b0);
    for (int i = 0; i < NS; i++) s_hrdata[i] = RD[i];
    s_hresp = '0; s_hreadyout = '1;
    step(); step();
    hreset = 1'b0;
    #2;
    chk("rst_hready", m_hready, 1'b1);
    chk("rst_hresp", m_hresp, 1'b0);
    chk("rst_err_valid", err_valid, 1'b0);

    // Zero-wait reads to each slave
    drive(32'h0000_0010, NONSEQ, 1'b0); #2; chk("hsel_s0", s_hsel, 3'b001); step();
    drive(32'h2000_0004, NONSEQ, 1'b0); #2; chk("hsel_s1", s_hsel, 3'b010);
    chk("rd_s0", m_hrdata, 32'hAAAA_0000); chk("rd_s0_resp", m_hresp, 1'b0); step();
    drive(32'h8000_0000, NONSEQ, 1'b0); #2; chk("hsel_s2", s_hsel, 3'b100);
    chk("rd_s1", m_hrdata, 32'hBBBB_1111); step();
    drive(32'h0, IDLE, 1'b0); #2; chk("rd_s2", m_hrdata, 32'hCCCC_2222);
    chk("rd_s2_ready", m_hready, 1'b1); step();

    // IDLE to an unmapped address
    drive(32'h4000_0000, IDLE, 1'b0); #2; chk("hsel_none", s_hsel, 3'b000); step();
    drive(32'h0, IDLE, 1'b0); #2;
    chk("idle_unmap_ready", m_hready, 1'b1); chk("idle_unmap_resp", m_hresp, 1'b0);
    chk("idle_unmap_err", err_valid, 1'b0); step();

    // Unmapped write, back-to-back unmapped, clear coincident with a third error
    drive(32'h4000_0000, NONSEQ, 1'b1); step();
    drive(32'h5000_0000, NONSEQ, 1'b0); #2;
    chk("ds_c1_ready", m_hready, 1'b0); chk("ds_c1_resp", m_hresp, 1'b1);
    chk("ds_err_valid", err_valid, 1'b1); step();
    #2; chk("ds_c2_ready", m_hready, 1'b1); chk("ds_c2_resp", m_hresp, 1'b1);
    chk("ds_err_cause", err_cause, 1'b0); chk("ds_err_addr", err_addr, 32'h4000_0000); step();
    drive(32'h6000_0000, NONSEQ, 1'b0); #2; chk("first_wins", err_addr, 32'h4000_0000); step();
    err_clr = 1'b1; #2; chk("pre_clr_valid", err_valid, 1'b1); step();
    err_clr = 1'b0; drive(32'h0, IDLE, 1'b0); #2;
    chk("clr_new_valid", err_valid, 1'b1); chk("clr_new_addr", err_addr, 32'h6000_0000); step();
    step();
    err_clr = 1'b1; step();
    err_clr = 1'b0; #2; chk("clr_only", err_valid, 1'b0);

    // Slave 1 hangs: four wait cycles, then two ERROR cycles
    s_hreadyout[1] = 1'b0;
    drive(32'h2000_0008, NONSEQ, 1'b0); step();
    drive(32'h0000_0020, NONSEQ, 1'b0);
    for (int k = 0; k < TO; k++) begin
      #2; chk("to_wait_ready", m_hready, 1'b0); chk("to_wait_resp", m_hresp, 1'b0); step();
    end
    #2; chk("to_err1_ready", m_hready, 1'b0); chk("to_err1_resp", m_hresp, 1'b1); step();
    #2; chk("to_err2_ready", m_hready, 1'b1); chk("to_err2_resp", m_hresp, 1'b1);
    chk("to_err_cause", err_cause, 1'b1); chk("to_err_addr", err_addr, 32'h2000_0008); step();
    s_hreadyout[1] = 1'b1; drive(32'h0, IDLE, 1'b0); #2;
    chk("after_to_rd", m_hrdata, 32'hAAAA_0000); chk("after_to_resp", m_hresp, 1'b0); step();

    // Slave's own two-cycle ERROR passes through untouched
    drive(32'h8000_0004, NONSEQ, 1'b0); step();
    s_hresp[2] = 1'b1; s_hreadyout[2] = 1'b0; drive(32'h0, IDLE, 1'b0); #2;
    chk("slv_err1_resp", m_hresp, 1'b1); chk("slv_err1_ready", m_hready, 1'b0); step();
    s_hreadyout[2] = 1'b1; #2;
    chk("slv_err2_ready", m_hready, 1'b1); chk("slv_err_keep", err_addr, 32'h2000_0008); step();
    s_hresp[2] = 1'b0;

    // Reset while the default slave is in its first ERROR cycle
    drive(32'h4000_0000, NONSEQ, 1'b0); step();
    hreset = 1'b1; drive(32'h0, IDLE, 1'b0); step();
    hreset = 1'b0; #2;
    chk("rst_err1_ready", m_hready, 1'b1); chk("rst_err1_resp", m_hresp, 1'b0);
    chk("rst_err1_valid", err_valid, 1'b0);
    drive(32'h2000_0004, NONSEQ, 1'b0); #1; chk("rst_err1_hsel", s_hsel, 3'b010); step();
    drive(32'h0, IDLE, 1'b0); #2; chk("rst_err1_rd", m_hrdata, 32'hBBBB_1111); step();

    // Reset while slave 0 is stalled
    s_hreadyout[0] = 1'b0;
    drive(32'h0000_0010, NONSEQ, 1'b0); step();
    drive(32'h0, IDLE, 1'b0); hreset = 1'b1; step();
    hreset = 1'b0; s_hreadyout[0] = 1'b1; #2;
    chk("rst_slv_ready", m_hready, 1'b1); chk("rst_slv_resp", m_hresp, 1'b0);
    chk("rst_slv_valid", err_valid, 1'b0);
    drive(32'h8000_0000, NONSEQ, 1'b0); step();
    drive(32'h0, IDLE, 1'b0); #2; chk("rst_slv_rd", m_hrdata, 32'hCCCC_2222); step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
